// File: rtl/ahb_split_slave_ctrl.sv
// AHB slave-side SPLIT controller for a shared resource.
// An accepted transfer starts a background job that keeps the resource busy.
// Unlocked transfers that arrive during a job are split, and the splitting
// master is recorded. When the job ends, all recorded masters are released
// together with a single hsplit pulse.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | ready, OKAY; accept, split or park a locked transfer
// ST_LOCKWAIT | locked transfer waiting for the job to drain (wait states)
// ST_SPLIT1   | first SPLIT cycle, hreadyout low
// ST_SPLIT2   | second SPLIT cycle, hreadyout high; transfers ignored
module ahb_split_slave_ctrl #(
  parameter int NUM_MASTERS    = 3,
  parameter int SERVICE_CYCLES = 4
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic        hready,
  input  logic [3:0]  hmaster,
  input  logic        hmastlock,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [15:0] hsplit,
  output logic        busy
);

  localparam int            CW  = $clog2(SERVICE_CYCLES + 1);
  localparam logic [CW-1:0] SVC = CW'(SERVICE_CYCLES);
  localparam logic [4:0]    NM  = 5'(NUM_MASTERS);
  localparam logic [1:0]    RESP_OKAY  = 2'b00;
  localparam logic [1:0]    RESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_LOCKWAIT, ST_SPLIT1, ST_SPLIT2} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] job_cnt, job_cnt_nxt;
  logic [15:0]   split_mask, split_mask_nxt;
  logic [15:0]   hsplit_nxt;
  logic          hreadyout_nxt;
  logic [1:0]    hresp_nxt;
  logic          valid, cnt_zero, accept, record;

  // Only NONSEQ/SEQ address phases that complete on the bus are transfers.
  assign valid    = hsel & hready & ((htrans == 2'b10) || (htrans == 2'b11));
  assign cnt_zero = (job_cnt == '0);
  assign busy     = ~cnt_zero;

  // Next state, job counter, split bookkeeping and next registered outputs.
  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    record         = 1'b0;
    split_mask_nxt = split_mask;
    hsplit_nxt     = '0;

    case (state)
      ST_IDLE: begin
        if (valid) begin
          if (cnt_zero) begin
            accept = 1'b1;
          end else if (!hmastlock) begin
            record    = 1'b1;
            state_nxt = ST_SPLIT1;
          end else begin
            state_nxt = ST_LOCKWAIT;
          end
        end
      end
      ST_LOCKWAIT: begin
        if (cnt_zero) begin
          accept    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_SPLIT1: state_nxt = ST_SPLIT2;
      ST_SPLIT2: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    if (accept)        job_cnt_nxt = SVC;
    else if (cnt_zero) job_cnt_nxt = '0;
    else               job_cnt_nxt = job_cnt - 1'b1;

    // Release and record never coincide: release needs an idle resource,
    // recording needs a busy one.
    if (cnt_zero && (split_mask != '0)) begin
      hsplit_nxt     = split_mask;
      split_mask_nxt = '0;
    end
    if (record && ({1'b0, hmaster} < NM)) begin
      split_mask_nxt[hmaster] = 1'b1;
    end

    hreadyout_nxt = !((state_nxt == ST_SPLIT1) || (state_nxt == ST_LOCKWAIT));
    hresp_nxt     = ((state_nxt == ST_SPLIT1) || (state_nxt == ST_SPLIT2)) ?
                    RESP_SPLIT : RESP_OKAY;
  end

  // State, counter, mask and output registers; reset drops any pending release.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state      <= ST_IDLE;
      job_cnt    <= '0;
      split_mask <= '0;
      hsplit     <= '0;
      hreadyout  <= 1'b1;
      hresp      <= RESP_OKAY;
    end else begin
      state      <= state_nxt;
      job_cnt    <= job_cnt_nxt;
      split_mask <= split_mask_nxt;
      hsplit     <= hsplit_nxt;
      hreadyout  <= hreadyout_nxt;
      hresp      <= hresp_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_split_slave_ctrl.sv
// Directed bench for ahb_split_slave_ctrl (3 masters, 4-cycle jobs).
// Inputs change 1ns after the rising edge; outputs are checked at that point.
module tb_ahb_split_slave_ctrl;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hready;
  logic [3:0]  hmaster;
  logic        hmastlock;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [15:0] hsplit;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // The slave is the only one on this bus, so bus HREADY is its own hreadyout.
  assign hready = hreadyout;

  always #5 hclk = ~hclk;

  ahb_split_slave_ctrl #(.NUM_MASTERS(3), .SERVICE_CYCLES(4)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .htrans    (htrans),
    .hready    (hready),
    .hmaster   (hmaster),
    .hmastlock (hmastlock),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hsplit    (hsplit),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drv(input logic [1:0] tr, input logic [3:0] m, input logic lock);
    hsel      = 1'b1;
    htrans    = tr;
    hmaster   = m;
    hmastlock = lock;
  endtask

  task automatic idle();
    hsel      = 1'b0;
    htrans    = 2'b00;
    hmaster   = 4'd0;
    hmastlock = 1'b0;
  endtask

  initial begin
    hresetn = 1'b0;
    idle();
    repeat (2) step();
    chk("rst_rdy",  32'(hreadyout), 32'd1);
    chk("rst_resp", 32'(hresp),     32'd0);
    chk("rst_hsplit", 32'(hsplit),  32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    hresetn = 1'b1;
    step();

    // Accept from master 1: zero-wait OKAY, busy for exactly 4 cycles.
    drv(2'b10, 4'd1, 1'b0);
    step();
    chk("acc_rdy",  32'(hreadyout), 32'd1);
    chk("acc_resp", 32'(hresp),     32'd0);
    chk("acc_busy", 32'(busy),      32'd1);
    idle();
    for (int i = 1; i < 4; i++) begin
      step();
      chk("acc_busy_hold", 32'(busy), 32'd1);
    end
    step();
    chk("acc_busy_end", 32'(busy), 32'd0);

    // BUSY htrans has no side effect.
    drv(2'b01, 4'd1, 1'b0);
    step();
    chk("busytr_nojob", 32'(busy), 32'd0);
    chk("busytr_rdy",   32'(hreadyout), 32'd1);
    idle();
    step();

    // Split and release of master 2; master 0 sampled in SPLIT2 is ignored.
    drv(2'b10, 4'd1, 1'b0);
    step();
    drv(2'b10, 4'd2, 1'b0);
    step();
    chk("sp_resp1", 32'(hresp),     32'd3);
    chk("sp_rdy1",  32'(hreadyout), 32'd0);
    chk("sp_mask",  32'(dut.split_mask), 32'h4);
    drv(2'b10, 4'd0, 1'b0);
    step();
    chk("sp_resp2", 32'(hresp),     32'd3);
    chk("sp_rdy2",  32'(hreadyout), 32'd1);
    step();
    idle();
    chk("sp_done_resp", 32'(hresp), 32'd0);
    chk("sp_ign_mask",  32'(dut.split_mask), 32'h4);
    chk("sp_busy_last", 32'(busy),  32'd1);
    step();
    chk("sp_busy_fall", 32'(busy),   32'd0);
    chk("sp_no_early",  32'(hsplit), 32'd0);
    step();
    chk("sp_release",   32'(hsplit), 32'h4);
    chk("sp_mask_clr",  32'(dut.split_mask), 32'h0);
    step();
    chk("sp_pulse_end", 32'(hsplit), 32'h0);

    // Multi-split: master 2 early, master 0 at job_cnt==1 -> single 0x5 pulse.
    drv(2'b10, 4'd1, 1'b0);
    step();
    drv(2'b10, 4'd2, 1'b0);
    step();
    idle();
    step();
    step();
    drv(2'b10, 4'd0, 1'b0);
    step();
    idle();
    chk("ms_resp",  32'(hresp), 32'd3);
    chk("ms_mask",  32'(dut.split_mask), 32'h5);
    chk("ms_busy",  32'(busy),  32'd0);
    step();
    chk("ms_release", 32'(hsplit), 32'h5);
    chk("ms_mask_clr", 32'(dut.split_mask), 32'h0);
    step();
    chk("ms_pulse_end", 32'(hsplit), 32'h0);

    // Edge timing: idle until job_cnt==1, then master 2 is split and released.
    drv(2'b10, 4'd1, 1'b0);
    step();
    idle();
    repeat (3) step();
    drv(2'b10, 4'd2, 1'b0);
    step();
    idle();
    chk("edge_resp", 32'(hresp), 32'd3);
    chk("edge_rdy",  32'(hreadyout), 32'd0);
    chk("edge_mask", 32'(dut.split_mask), 32'h4);
    step();
    chk("edge_release", 32'(hsplit), 32'h4);
    step();
    chk("edge_pulse_end", 32'(hsplit), 32'h0);
    chk("edge_idle_resp", 32'(hresp),  32'd0);

    // Out-of-range master number is never recorded or released.
    drv(2'b10, 4'd1, 1'b0);
    step();
    drv(2'b10, 4'd5, 1'b0);
    step();
    idle();
    chk("oor_mask", 32'(dut.split_mask), 32'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("oor_hsplit", 32'(hsplit), 32'h0);
    end

    // Locked transfer during a job waits, then starts a new 4-cycle job.
    drv(2'b10, 4'd1, 1'b0);
    step();
    drv(2'b10, 4'd2, 1'b1);
    step();
    idle();
    chk("lk_rdy",  32'(hreadyout), 32'd0);
    chk("lk_resp", 32'(hresp),     32'd0);
    repeat (3) step();
    chk("lk_wait_rdy",  32'(hreadyout), 32'd0);
    chk("lk_wait_busy", 32'(busy),      32'd0);
    step();
    chk("lk_acc_rdy",  32'(hreadyout), 32'd1);
    chk("lk_acc_resp", 32'(hresp),     32'd0);
    chk("lk_acc_busy", 32'(busy),      32'd1);
    chk("lk_mask",     32'(dut.split_mask), 32'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("lk_busy_hold", 32'(busy), 32'd1);
    end
    step();
    chk("lk_busy_end", 32'(busy), 32'd0);

    // Async reset during SPLIT1 with a pending split: immediate, no release.
    drv(2'b10, 4'd1, 1'b0);
    step();
    drv(2'b10, 4'd2, 1'b0);
    step();
    idle();
    chk("ar_pre_rdy", 32'(hreadyout), 32'd0);
    #2;
    hresetn = 1'b0;
    #1;
    chk("ar_rdy",    32'(hreadyout), 32'd1);
    chk("ar_resp",   32'(hresp),     32'd0);
    chk("ar_hsplit", 32'(hsplit),    32'd0);
    chk("ar_busy",   32'(busy),      32'd0);
    chk("ar_mask",   32'(dut.split_mask), 32'h0);
    step();
    hresetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ar_no_release", 32'(hsplit), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
